// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount accumulator.
//   state_t : frame FSM state (ST_ACCUM collecting words, ST_HOLD presenting result)
//   ones_w  : width needed to hold popcount of a wl-bit word
//   sum_w   : width needed to hold the total ones of a full frame
//   cnt_w   : width needed to hold a word count 0..max_words
package popcount_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   function automatic int ones_w(input int wl);
      return $clog2(wl + 1);
   endfunction

   function automatic int sum_w(input int wl, input int max_words);
      return $clog2(wl * max_words + 1);
   endfunction

   function automatic int cnt_w(input int max_words);
      return $clog2(max_words + 1);
   endfunction

endpackage

// File: rtl/count_ones.sv
// Combinational population count of one WL-bit word.
//   din  : word to count
//   ones : number of set bits in din
module count_ones
   import popcount_pkg::*;
#(
   parameter int WL = 32
) (
   input  logic [WL-1:0]         din,
   output logic [ones_w(WL)-1:0] ones
);

   localparam int ONES_W = ones_w(WL);

   always_comb begin
      ones = '0;
      for (int i = 0; i < WL; i++) begin
         ones = ones + ONES_W'(din[i]);
      end
   end

endmodule

// File: rtl/popcount_accum.sv
// Frame-based popcount accumulator. Sums the set bits of every word in a
// frame (up to MAX_WORDS words), then presents the total, the word count and
// an overflow flag until the downstream side accepts it.
//   clk, rst                   : clock, synchronous active-high reset
//   din, din_valid, din_last   : input word stream, din_last marks frame end
//   din_ready                  : high while collecting words
//   dout_sum, dout_words       : total ones / words counted in the frame
//   dout_overflow              : frame carried more than MAX_WORDS words
//   dout_valid, dout_ready     : result handshake
//
// state    | meaning
// ---------+------------------------------------------------
// ST_ACCUM | accepting words, accumulating sum and count
// ST_HOLD  | result registered on dout_*, waiting for dout_ready
module popcount_accum
   import popcount_pkg::*;
#(
   parameter int WL        = 32,
   parameter int MAX_WORDS = 256
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [WL-1:0]                       din,
   input  logic                                din_valid,
   input  logic                                din_last,
   output logic                                din_ready,
   output logic [sum_w(WL, MAX_WORDS)-1:0]     dout_sum,
   output logic [cnt_w(MAX_WORDS)-1:0]         dout_words,
   output logic                                dout_overflow,
   output logic                                dout_valid,
   input  logic                                dout_ready
);

   localparam int SUM_W  = sum_w(WL, MAX_WORDS);
   localparam int CNT_W  = cnt_w(MAX_WORDS);
   localparam int ONES_W = ones_w(WL);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

   state_t             state_q, state_d;
   logic [SUM_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [SUM_W-1:0]   sum_out_q, sum_out_d;
   logic [CNT_W-1:0]   words_out_q, words_out_d;
   logic               ovf_out_q, ovf_out_d;

   logic [ONES_W-1:0]  word_ones;
   logic               accept;

   count_ones #(.WL(WL)) u_count_ones (
      .din  (din),
      .ones (word_ones)
   );

   assign accept = din_valid && (state_q == ST_ACCUM);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      sum_out_d   = sum_out_q;
      words_out_d = words_out_q;
      ovf_out_d   = ovf_out_q;

      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               // Words past MAX_WORDS are dropped, so the accumulator and
               // counter can never wrap; only the sticky flag records them.
               if (cnt_q < MAX_CNT) begin
                  acc_d = acc_q + SUM_W'(word_ones);
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
               if (din_last) begin
                  sum_out_d   = acc_d;
                  words_out_d = cnt_d;
                  ovf_out_d   = ovf_d;
                  state_d     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (dout_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         sum_out_q   <= '0;
         words_out_q <= '0;
         ovf_out_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         sum_out_q   <= sum_out_d;
         words_out_q <= words_out_d;
         ovf_out_q   <= ovf_out_d;
      end
   end

   assign din_ready     = (state_q == ST_ACCUM);
   assign dout_valid    = (state_q == ST_HOLD);
   assign dout_sum      = sum_out_q;
   assign dout_words    = words_out_q;
   assign dout_overflow = ovf_out_q;

endmodule

// File: tb/tb_popcount_accum.sv
// Directed and randomized bench for popcount_accum (WL=32, MAX_WORDS=4).
module tb_popcount_accum;

   localparam int WL        = 32;
   localparam int MAX_WORDS = 4;

   logic        clk;
   logic        rst;
   logic [31:0] din;
   logic        din_valid;
   logic        din_last;
   logic        din_ready;
   logic [7:0]  dout_sum;
   logic [2:0]  dout_words;
   logic        dout_overflow;
   logic        dout_valid;
   logic        dout_ready;

   int n_vec = 0;
   int n_err = 0;

   popcount_accum #(.WL(WL), .MAX_WORDS(MAX_WORDS)) dut (
      .clk           (clk),
      .rst           (rst),
      .din           (din),
      .din_valid     (din_valid),
      .din_last      (din_last),
      .din_ready     (din_ready),
      .dout_sum      (dout_sum),
      .dout_words    (dout_words),
      .dout_overflow (dout_overflow),
      .dout_valid    (dout_valid),
      .dout_ready    (dout_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int               n;
      logic [5:0][31:0] w;
      int               hold;
      int               exp_sum;
      int               exp_words;
      logic             exp_ovf;
   } vec_t;

   vec_t vecs[7];

   function automatic vec_t mk(input int n, input logic [31:0] w0, w1, w2, w3, w4, w5,
                               input int hold, input int s, input int wd, input logic o);
      vec_t v;
      v.n = n;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
      v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
      v.hold = hold;
      v.exp_sum = s;
      v.exp_words = wd;
      v.exp_ovf = o;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge after the word was accepted.
   task automatic send_word(input logic [31:0] w, input logic last);
      int t = 0;
      din       = w;
      din_last  = last;
      din_valid = 1'b1;
      while (!din_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!din_ready) chk("din_ready_timeout", 64'(din_ready), 64'd1);
      @(negedge clk);
      din_valid = 1'b0;
      din_last  = 1'b0;
   endtask

   task automatic get_result(input int exp_sum, input int exp_words, input logic exp_ovf,
                             input int hold);
      int t = 0;
      while (!dout_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("dout_valid", 64'(dout_valid), 64'd1);
      chk("dout_sum", 64'(dout_sum), 64'(exp_sum));
      chk("dout_words", 64'(dout_words), 64'(exp_words));
      chk("dout_overflow", 64'(dout_overflow), 64'(exp_ovf));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 64'(dout_valid), 64'd1);
         chk("hold_din_ready", 64'(din_ready), 64'd0);
         chk("hold_sum", 64'(dout_sum), 64'(exp_sum));
         chk("hold_words", 64'(dout_words), 64'(exp_words));
      end
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      chk("post_valid", 64'(dout_valid), 64'd0);
      chk("post_din_ready", 64'(din_ready), 64'd1);
      chk("post_sum_kept", 64'(dout_sum), 64'(exp_sum));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      din = '0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
      rst = 1'b1;

      vecs[0] = mk(2, 32'hFFFF_FFFF, 32'h0000_000F, 0, 0, 0, 0, 0, 36, 2, 1'b0);
      vecs[1] = mk(1, 32'h8000_0001, 0, 0, 0, 0, 0, 0, 2, 1, 1'b0);
      vecs[2] = mk(6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 128, 4, 1'b1);
      vecs[3] = mk(1, 32'h0000_0003, 0, 0, 0, 0, 0, 5, 2, 1, 1'b0);
      vecs[4] = mk(4, 32'h1, 32'h3, 32'h7, 32'hF, 0, 0, 1, 10, 4, 1'b0);
      vecs[5] = mk(5, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 4, 1'b1);
      vecs[6] = mk(1, 32'h0, 0, 0, 0, 0, 0, 2, 0, 1, 1'b0);

      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_din_ready", 64'(din_ready), 64'd1);
      chk("rst_dout_valid", 64'(dout_valid), 64'd0);
      chk("rst_dout_sum", 64'(dout_sum), 64'd0);
      chk("rst_dout_words", 64'(dout_words), 64'd0);
      chk("rst_dout_ovf", 64'(dout_overflow), 64'd0);

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < vecs[v].n; i++) send_word(vecs[v].w[i], i == vecs[v].n - 1);
         chk("latency_valid", 64'(dout_valid), 64'd1);
         chk("latency_din_ready", 64'(din_ready), 64'd0);
         get_result(vecs[v].exp_sum, vecs[v].exp_words, vecs[v].exp_ovf, vecs[v].hold);
      end

      // Reset mid-frame: the partial frame must vanish without a result.
      send_word(32'hFF, 1'b0);
      send_word(32'hFF, 1'b0);
      pulse_reset();
      chk("midrst_valid", 64'(dout_valid), 64'd0);
      chk("midrst_din_ready", 64'(din_ready), 64'd1);
      chk("midrst_sum", 64'(dout_sum), 64'd0);
      send_word(32'h1, 1'b1);
      get_result(1, 1, 1'b0, 0);

      // Reset while a result is pending: it is discarded.
      send_word(32'h7, 1'b1);
      chk("hold_pre_rst_valid", 64'(dout_valid), 64'd1);
      pulse_reset();
      chk("holdrst_valid", 64'(dout_valid), 64'd0);
      chk("holdrst_din_ready", 64'(din_ready), 64'd1);
      chk("holdrst_sum", 64'(dout_sum), 64'd0);
      chk("holdrst_words", 64'(dout_words), 64'd0);
      send_word(32'h5, 1'b0);
      send_word(32'h5, 1'b1);
      get_result(4, 2, 1'b0, 1);

      // Random frames with input gaps and output backpressure.
      for (int f = 0; f < 1000; f++) begin
         int n;
         int m_sum;
         int m_cnt;
         logic m_ovf;
         logic [31:0] w;
         n = int'($urandom_range(1, 6));
         m_sum = 0;
         m_cnt = 0;
         m_ovf = 1'b0;
         for (int i = 0; i < n; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            case ($urandom_range(0, 3))
               0:       w = 32'h0;
               1:       w = 32'hFFFF_FFFF;
               default: w = $urandom;
            endcase
            if (m_cnt < MAX_WORDS) begin
               m_sum += $countones(w);
               m_cnt++;
            end else begin
               m_ovf = 1'b1;
            end
            send_word(w, i == n - 1);
         end
         get_result(m_sum, m_cnt, m_ovf, int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 SHALL have parameter WL, default 32, input word width in bits (WL >= 1).
REQ-002 SHALL have parameter MAX_WORDS, default 256, maximum words counted per frame (MAX_WORDS >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  WL  data word to be popcounted.
REQ-006 SHALL have port din_valid  input  1  din/din_last qualified.
REQ-007 SHALL have port din_last  input  1  marks the final word of a frame.
REQ-008 SHALL have port din_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have port dout_sum  output  SUM_W  total ones in the frame; SUM_W = $clog2(WL*MAX_WORDS+1).
REQ-010 SHALL have port dout_words  output  CNT_W  words counted in the frame; CNT_W = $clog2(MAX_WORDS+1).
REQ-011 SHALL have port dout_overflow  output  1  frame exceeded MAX_WORDS words.
REQ-012 SHALL have port dout_valid  output  1  result fields qualified.
REQ-013 SHALL have port dout_ready  input  1  downstream accepts the result.

Function
REQ-014 SHALL implement a two-state FSM: ACCUM (collecting words) and HOLD (presenting result).
REQ-015 SHALL drive din_ready = 1 only in ACCUM; dout_valid = 1 only in HOLD.
REQ-016 SHALL accept a word when din_valid && din_ready; no other input cycle has any effect.
REQ-017 On each accepted word with words < MAX_WORDS, SHALL add popcount(din) to the sum accumulator and increment the word counter, both in the same cycle.
REQ-018 On an accepted word with words == MAX_WORDS, SHALL leave sum and words unchanged and set the sticky overflow flag.
REQ-019 On an accepted word with din_last = 1, SHALL apply REQ-017/REQ-018 for that word, register sum/words/overflow onto dout_*, and move to HOLD; dout_valid rises the cycle after the last word is accepted (latency 1).
REQ-020 A single-word frame (din_last on first word) SHALL be valid and yield words = 1.
REQ-021 In HOLD, dout_* SHALL stay stable while dout_valid && !dout_ready.
REQ-022 In HOLD with dout_ready = 1, SHALL return to ACCUM next cycle, with accumulator, counter and overflow cleared; din_ready is 0 during HOLD (one-cycle bubble per frame).
REQ-023 Arithmetic SHALL never wrap: sum <= WL*MAX_WORDS and words <= MAX_WORDS by construction of REQ-018.
REQ-024 din_valid deasserting mid-frame SHALL only stall; partial state is retained indefinitely.
REQ-025 dout_sum/dout_words/dout_overflow outside HOLD SHALL hold the last presented result (zero after reset).

Reset
REQ-026 rst SHALL take effect on the next rising clk edge regardless of state, including mid-frame and in HOLD.
REQ-027 Reset values SHALL be: state ACCUM, din_ready 1, dout_valid 0, dout_sum 0, dout_words 0, dout_overflow 0, accumulator 0, counter 0.
REQ-028 A frame in progress or an unaccepted result at reset SHALL be discarded, with no output.

Structure
REQ-029 The FSM state enum type SHALL live in a shared package (popcount_pkg) with the SUM_W/CNT_W width helper functions.
REQ-030 The per-word popcount SHALL use one instance of the existing combinational count_ones sub-module with WL passed through.
REQ-031 SHALL contain no latches and no multicycle paths; the only registers are the FSM, accumulator, counter, overflow flag and output registers.

Verification (WL=32, MAX_WORDS=4 unless noted)
REQ-032 Frame 0xFFFFFFFF, 0x0000000F(last), dout_ready = 1 -> dout_valid one cycle after last; sum = 36, words = 2, overflow = 0; din_ready = 0 for exactly 1 cycle.
REQ-033 Single word 0x80000001(last) -> sum = 2, words = 1.
REQ-034 Six words 0xFFFFFFFF, last on sixth -> sum = 128, words = 4, overflow = 1.
REQ-035 Frame 0x3 (last) with dout_ready held 0 for 5 cycles -> dout_valid and fields stable for 5 cycles, din_ready = 0; then accepted and next frame starts with cleared state.
REQ-036 Two words accepted, then rst pulsed for 1 cycle, then 0x1(last) -> sum = 1, words = 1; no result produced for the aborted frame.
REQ-037 Random din_valid/dout_ready gaps over 1000 frames -> every result matches a reference model sum/word count.
